// File: rtl/noc_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : noc_pkg
//  Description : Shared definitions for spike events exchanged between the
//                spike event queue and the NoC packetiser.
//                Event word layout: {neuron_id (MSBs), timestep (LSBs)}.
//  Revision    : 1.0 - initial release
// ============================================================================
package noc_pkg;

  localparam int DEFAULT_NUM_NEURONS = 4;
  localparam int DEFAULT_FIFO_DEPTH  = 8;
  localparam int DEFAULT_TS_W        = 16;
  localparam int DEFAULT_ID_W        = $clog2(DEFAULT_NUM_NEURONS);

  // Event width for the default configuration.
  localparam int SPIKE_EVT_W = DEFAULT_ID_W + DEFAULT_TS_W;

  // Event width for an arbitrary configuration.
  function automatic int spike_evt_w(input int id_w, input int ts_w);
    return id_w + ts_w;
  endfunction

  // The timestep occupies the LSBs, so the id field starts at ts_w.
  function automatic int evt_ts_lsb();
    return 0;
  endfunction

  function automatic int evt_id_lsb(input int ts_w);
    return ts_w;
  endfunction

endpackage
`default_nettype wire

// File: rtl/spike_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : spike_fifo
//  Description : Synchronous show-ahead FIFO with registered pointers and
//                occupancy count. The head entry is presented combinationally
//                from storage and reads as zero while the FIFO is empty.
//  Ports       : clk, rst (async, active-high)
//                push / push_data  - write request (ignored when full)
//                pop               - remove head (ignored when empty)
//                head_data         - current head entry
//                level / full / empty - occupancy status
//  Revision    : 1.0 - initial release
// ============================================================================
module spike_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8,
  parameter int LVL_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head_data,
  output logic [LVL_W-1:0] level,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0] level_q, level_d;
  logic             push_ok;
  logic             pop_ok;

  assign full  = (level_q == LVL_W'(DEPTH));
  assign empty = (level_q == '0);
  assign level = level_q;

  always_comb begin
    push_ok  = push && !full;
    pop_ok   = pop && !empty;
    // DEPTH is a power of two, so pointer increment wraps naturally.
    wr_ptr_d = push_ok ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = pop_ok  ? rd_ptr_q + AW'(1) : rd_ptr_q;
    level_d  = level_q;
    case ({push_ok, pop_ok})
      2'b10:   level_d = level_q + LVL_W'(1);
      2'b01:   level_d = level_q - LVL_W'(1);
      default: level_d = level_q;
    endcase
    head_data = empty ? '0 : mem_q[rd_ptr_q];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  // Storage needs no reset: stale entries are never visible while empty.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem_q[wr_ptr_q] <= push_data;
    end
  end

endmodule
`default_nettype wire

// File: rtl/spike_event_queue.sv
`default_nettype none
// ============================================================================
//  Module      : spike_event_queue
//  Description : Round-robin capture of neuron spike flags into a
//                timestamped event FIFO, with a one-cycle ack per core.
//  Ports       : clk, rst (async, active-high)
//                timestep        - current timestep, stamped on capture
//                spike_detected  - level spike flag per core
//                spike_resolved  - registered one-cycle ack per core
//                evt_valid/evt_ready/evt_neuron_id/evt_timestep - drain port
//                fifo_level, fifo_full - occupancy status
//  Revision    : 1.0 - initial release
// ============================================================================
module spike_event_queue
  import noc_pkg::*;
#(
  parameter int NUM_NEURONS = DEFAULT_NUM_NEURONS,
  parameter int FIFO_DEPTH  = DEFAULT_FIFO_DEPTH,
  parameter int TS_W        = DEFAULT_TS_W,
  parameter int ID_W        = $clog2(NUM_NEURONS)
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [TS_W-1:0]               timestep,
  input  logic [NUM_NEURONS-1:0]        spike_detected,
  output logic [NUM_NEURONS-1:0]        spike_resolved,
  output logic                          evt_valid,
  input  logic                          evt_ready,
  output logic [ID_W-1:0]               evt_neuron_id,
  output logic [TS_W-1:0]               evt_timestep,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          fifo_full
);

  localparam int EVT_W  = spike_evt_w(ID_W, TS_W);
  localparam int LVL_W  = $clog2(FIFO_DEPTH) + 1;
  localparam int ID_LSB = evt_id_lsb(TS_W);
  localparam int TS_LSB = evt_ts_lsb();

  logic [NUM_NEURONS-1:0] lock_q, lock_d;
  logic [NUM_NEURONS-1:0] resolved_q, resolved_d;
  logic [ID_W-1:0]        ptr_q, ptr_d;
  logic [NUM_NEURONS-1:0] pending;
  logic                   gnt_valid;
  logic [ID_W-1:0]        gnt_id;
  logic [EVT_W-1:0]       push_data;
  logic [EVT_W-1:0]       head_data;
  logic                   fifo_empty;

  // Round-robin arbiter: scan from ptr+1 upward (mod NUM_NEURONS); the
  // first pending core wins. No grant while the FIFO is full, so the
  // core keeps waiting and nothing is dropped.
  always_comb begin
    int idx;
    idx       = 0;
    pending   = spike_detected & ~lock_q;
    gnt_valid = 1'b0;
    gnt_id    = '0;
    if (!fifo_full) begin
      for (int off = 1; off <= NUM_NEURONS; off++) begin
        idx = int'(ptr_q) + off;
        if (idx >= NUM_NEURONS) begin
          idx = idx - NUM_NEURONS;
        end
        if (!gnt_valid && pending[idx[ID_W-1:0]]) begin
          gnt_valid = 1'b1;
          gnt_id    = idx[ID_W-1:0];
        end
      end
    end
  end

  // A lock stays set while the core keeps its flag high after the ack,
  // so a long-held flag is captured exactly once.
  always_comb begin
    ptr_d      = gnt_valid ? gnt_id : ptr_q;
    lock_d     = lock_q & spike_detected;
    resolved_d = '0;
    if (gnt_valid) begin
      lock_d[gnt_id]     = 1'b1;
      resolved_d[gnt_id] = 1'b1;
    end
    push_data = {gnt_id, timestep};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lock_q     <= '0;
      resolved_q <= '0;
      ptr_q      <= ID_W'(NUM_NEURONS - 1);
    end else begin
      lock_q     <= lock_d;
      resolved_q <= resolved_d;
      ptr_q      <= ptr_d;
    end
  end

  spike_fifo #(
    .WIDTH (EVT_W),
    .DEPTH (FIFO_DEPTH),
    .LVL_W (LVL_W)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (gnt_valid),
    .push_data (push_data),
    .pop       (evt_ready),
    .head_data (head_data),
    .level     (fifo_level),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  assign spike_resolved = resolved_q;
  assign evt_valid      = !fifo_empty;
  assign evt_neuron_id  = head_data[ID_LSB +: ID_W];
  assign evt_timestep   = head_data[TS_LSB +: TS_W];

endmodule
`default_nettype wire

// File: tb/tb_spike_event_queue.sv
`default_nettype none
// ============================================================================
//  Module      : tb_spike_event_queue
//  Description : Directed self-checking bench for spike_event_queue
//                (4 neurons, 8-deep FIFO, 16-bit timestep).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_spike_event_queue;

  localparam int NN = 4;
  localparam int FD = 8;
  localparam int TW = 16;
  localparam int IW = 2;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [TW-1:0] timestep = '0;
  logic [NN-1:0] spike_detected = '0;
  logic [NN-1:0] spike_resolved;
  logic          evt_valid;
  logic          evt_ready = 1'b0;
  logic [IW-1:0] evt_neuron_id;
  logic [TW-1:0] evt_timestep;
  logic [3:0]    fifo_level;
  logic          fifo_full;

  int n_vec = 0;
  int n_mis = 0;

  always #5 clk = ~clk;

  spike_event_queue #(
    .NUM_NEURONS (NN),
    .FIFO_DEPTH  (FD),
    .TS_W        (TW)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .timestep       (timestep),
    .spike_detected (spike_detected),
    .spike_resolved (spike_resolved),
    .evt_valid      (evt_valid),
    .evt_ready      (evt_ready),
    .evt_neuron_id  (evt_neuron_id),
    .evt_timestep   (evt_timestep),
    .fifo_level     (fifo_level),
    .fifo_full      (fifo_full)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance one cycle; outputs are sampled 1ns after the active edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  // Raise a single core's flag for one cycle, expect its ack, then drop it.
  task automatic single_spike(input int n, input logic [TW-1:0] ts, input string tag);
    spike_detected = NN'(1) << n;
    timestep       = ts;
    step();
    check_eq(tag, 32'(spike_resolved), 32'(NN'(1) << n));
    spike_detected = '0;
    step();
  endtask

  // Watchdog so the run always terminates.
  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [IW-1:0] exp_id [8];
    logic [TW-1:0] exp_ts [8];

    // ---------------- reset state ----------------
    step();
    check_eq("rst_resolved", 32'(spike_resolved), 32'h0);
    check_eq("rst_valid",    32'(evt_valid),      32'h0);
    check_eq("rst_level",    32'(fifo_level),     32'h0);
    check_eq("rst_full",     32'(fifo_full),      32'h0);
    check_eq("rst_id",       32'(evt_neuron_id),  32'h0);
    check_eq("rst_ts",       32'(evt_timestep),   32'h0);
    rst = 1'b0;

    // ---------------- 1: single spike held 4 cycles ----------------
    timestep       = 16'd5;
    spike_detected = 4'b0010;
    step();
    check_eq("t1_resolved", 32'(spike_resolved), 32'h2);
    check_eq("t1_valid",    32'(evt_valid),      32'h1);
    check_eq("t1_id",       32'(evt_neuron_id),  32'h1);
    check_eq("t1_ts",       32'(evt_timestep),   32'h5);
    step();
    check_eq("t1_pulse_len", 32'(spike_resolved), 32'h0);
    step();
    step();
    check_eq("t1_no_dup", 32'(fifo_level), 32'h1);
    spike_detected = '0;
    evt_ready      = 1'b1;
    step();
    check_eq("t1_popped", 32'(fifo_level), 32'h0);
    step();
    check_eq("t1_empty_pop", 32'(fifo_level), 32'h0);
    check_eq("t1_empty_vld", 32'(evt_valid),  32'h0);

    // ---------------- 2: simultaneous spikes ----------------
    do_reset();
    spike_detected = 4'b1111;
    timestep       = 16'd10;
    for (int i = 0; i < 4; i++) begin
      step();
      timestep = 16'(11 + i);
      check_eq("t2_resolved", 32'(spike_resolved), 32'(4'b0001 << i));
      check_eq("t2_id",       32'(evt_neuron_id),  32'(i));
      check_eq("t2_ts",       32'(evt_timestep),   32'(10 + i));
      check_eq("t2_level",    32'(fifo_level),     32'h1);
    end
    spike_detected = '0;
    step();
    check_eq("t2_drained",  32'(fifo_level),     32'h0);
    check_eq("t2_no_extra", 32'(spike_resolved), 32'h0);

    // ---------------- 3: round-robin fairness ----------------
    single_spike(2, 16'd20, "t3_setup");
    spike_detected = 4'b0101;
    timestep       = 16'd21;
    step();
    check_eq("t3_first",     32'(spike_resolved), 32'h1);
    check_eq("t3_first_id",  32'(evt_neuron_id),  32'h0);
    step();
    check_eq("t3_second",    32'(spike_resolved), 32'h4);
    check_eq("t3_second_id", 32'(evt_neuron_id),  32'h2);
    spike_detected = '0;
    step();
    step();
    check_eq("t3_drained", 32'(fifo_level), 32'h0);

    // ---------------- 4: backpressure ----------------
    evt_ready = 1'b0;
    for (int j = 0; j < 8; j++) begin
      single_spike(j % 4, 16'(100 + j), "t4_fill_ack");
    end
    check_eq("t4_level8", 32'(fifo_level), 32'h8);
    check_eq("t4_full",   32'(fifo_full),  32'h1);
    spike_detected = 4'b0001;
    timestep       = 16'd200;
    step();
    check_eq("t4_blocked_ack", 32'(spike_resolved), 32'h0);
    check_eq("t4_blocked_lvl", 32'(fifo_level),     32'h8);
    step();
    check_eq("t4_blocked_ack2", 32'(spike_resolved), 32'h0);
    evt_ready = 1'b1;
    step();
    evt_ready = 1'b0;
    check_eq("t4_pop_noack", 32'(spike_resolved), 32'h0);
    check_eq("t4_pop_level", 32'(fifo_level),     32'h7);
    check_eq("t4_pop_full",  32'(fifo_full),      32'h0);
    step();
    check_eq("t4_late_ack",   32'(spike_resolved), 32'h1);
    check_eq("t4_late_level", 32'(fifo_level),     32'h8);
    for (int e = 0; e < 7; e++) begin
      exp_id[e] = IW'((e + 1) % 4);
      exp_ts[e] = TW'(101 + e);
    end
    exp_id[7] = 2'd0;
    exp_ts[7] = 16'd200;
    spike_detected = '0;
    evt_ready      = 1'b1;
    for (int e = 0; e < 8; e++) begin
      check_eq("t4_drain_id", 32'(evt_neuron_id), 32'(exp_id[e]));
      check_eq("t4_drain_ts", 32'(evt_timestep),  32'(exp_ts[e]));
      step();
    end
    check_eq("t4_empty", 32'(fifo_level), 32'h0);
    check_eq("t4_nvld",  32'(evt_valid),  32'h0);

    // ---------------- 5: concurrent push/pop ----------------
    evt_ready = 1'b0;
    for (int n = 1; n < 4; n++) begin
      single_spike(n, 16'(300 + n), "t5_fill_ack");
    end
    check_eq("t5_level3", 32'(fifo_level), 32'h3);
    evt_ready      = 1'b1;
    spike_detected = 4'b0001;
    timestep       = 16'd400;
    step();
    spike_detected = '0;
    check_eq("t5_level_same", 32'(fifo_level),     32'h3);
    check_eq("t5_ack",        32'(spike_resolved), 32'h1);
    check_eq("t5_head_a",     32'(evt_neuron_id),  32'h2);
    check_eq("t5_head_a_ts",  32'(evt_timestep),   32'd302);
    step();
    check_eq("t5_level2",     32'(fifo_level),     32'h2);
    check_eq("t5_head_b",     32'(evt_neuron_id),  32'h3);
    step();
    check_eq("t5_head_c",     32'(evt_neuron_id),  32'h0);
    check_eq("t5_head_c_ts",  32'(evt_timestep),   32'd400);
    step();
    check_eq("t5_empty", 32'(fifo_level), 32'h0);

    // ---------------- 6: reset mid-operation ----------------
    evt_ready = 1'b0;
    for (int n = 0; n < 3; n++) begin
      single_spike(n, 16'(500 + n), "t6_fill_ack");
    end
    spike_detected = 4'b1000;
    timestep       = 16'd503;
    step();
    check_eq("t6_level4", 32'(fifo_level),     32'h4);
    check_eq("t6_ack",    32'(spike_resolved), 32'h8);
    #2;
    rst = 1'b1;
    #1;
    check_eq("t6_rst_resolved", 32'(spike_resolved), 32'h0);
    check_eq("t6_rst_valid",    32'(evt_valid),      32'h0);
    check_eq("t6_rst_level",    32'(fifo_level),     32'h0);
    check_eq("t6_rst_full",     32'(fifo_full),      32'h0);
    check_eq("t6_rst_id",       32'(evt_neuron_id),  32'h0);
    check_eq("t6_rst_ts",       32'(evt_timestep),   32'h0);
    step();
    rst      = 1'b0;
    timestep = 16'd600;
    step();
    check_eq("t6_recap_ack",   32'(spike_resolved), 32'h8);
    check_eq("t6_recap_id",    32'(evt_neuron_id),  32'h3);
    check_eq("t6_recap_ts",    32'(evt_timestep),   32'd600);
    check_eq("t6_recap_level", 32'(fifo_level),     32'h1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/spike_event_queue.md
Name: spike_event_queue

Overview:
Downstream stage of the neuron bank. It monitors the spike_detected flags of NUM_NEURONS neuron cores and grants pending spikes with a round-robin arbiter. Each granted spike is stamped with the current timestep and pushed into a FIFO, and the owning core receives a one-cycle spike_resolved pulse. The CPU/NoC packetiser drains events through a valid/ready port.

Parameters:
NUM_NEURONS, 4, number of neuron cores monitored (2..32)
FIFO_DEPTH, 8, event FIFO entries (power of 2, >=2)
TS_W, 16, timestep tag width
ID_W, $clog2(NUM_NEURONS), neuron index width (derived)

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-high reset
timestep  in  TS_W  current simulation timestep, sampled at capture
spike_detected  in  NUM_NEURONS  level flag per core; high until the core returns to idle
spike_resolved  out  NUM_NEURONS  one-cycle registered ack per core
evt_valid  out  1  FIFO non-empty
evt_ready  in  1  consumer accepts the head event
evt_neuron_id  out  ID_W  head event neuron index
evt_timestep  out  TS_W  head event timestep
fifo_level  out  $clog2(FIFO_DEPTH)+1  occupancy
fifo_full  out  1  occupancy == FIFO_DEPTH

Behaviour:
- Clock and reset: one clock, clk. Reset rst is asynchronous and active-high.
- Reset values:
  - spike_resolved=0, evt_valid=0, fifo_level=0, fifo_full=0.
  - evt_neuron_id and evt_timestep=0.
  - Lock mask cleared.
  - RR pointer = NUM_NEURONS-1, so neuron 0 wins first.
- Lock mask lock[i]:
  - Set on grant to neuron i.
  - Cleared on any cycle where spike_detected[i]==0.
  - Pending vector = spike_detected & ~lock.
  - Purpose: a core holds spike_detected for several cycles after the ack, and the lock prevents capturing the same spike twice.
- Arbiter:
  - Each cycle with pending!=0 and fifo_full==0, grant exactly one neuron.
  - Search starts at ptr+1 modulo NUM_NEURONS; the first set pending bit wins.
  - ptr <= granted index. ptr is unchanged when nothing is granted.
- Capture latency (grant decided in cycle k):
  - At edge end of k: push {id, timestep sampled in k}, set lock[id].
  - spike_resolved[id]=1 during cycle k+1 only.
  - Event visible on evt_* in cycle k+1 if the FIFO was empty.
- Backpressure: when fifo_full, no grant occurs. Neurons stay in their wait state with spike_resolved low. No events are dropped.
- FIFO:
  - Show-ahead, registered pointers and count.
  - Pop when evt_valid && evt_ready.
  - Simultaneous push and pop when not full: both occur, fifo_level unchanged.
  - When full with a pop this cycle, no push (decision uses registered fifo_full). The push resumes the next cycle.
  - Pop when empty is ignored.
  - Pointers wrap modulo FIFO_DEPTH.
- Simultaneous spikes: at most one grant per cycle. N simultaneous spikes are drained over N cycles in RR order.
- spike_detected deasserting before grant: no event, no ack. The flag is treated as withdrawn.
- Reset mid-operation:
  - FIFO contents discarded and lock cleared.
  - In-flight spike_resolved forced low.
  - A core still holding spike_detected after reset is re-captured normally.
- evt_* outputs hold their value while evt_valid && !evt_ready.

Decomposition:
- Shared package (noc_pkg):
  - SPIKE_EVT_W = ID_W+TS_W
  - Event field offsets {id in MSBs, timestep in LSBs}
  - Default FIFO_DEPTH
  - Reused by the NoC packetiser.
- Sub-module: spike_fifo (synchronous show-ahead FIFO, parameterised width/depth, outputs level/full/empty).
- Arbiter and lock logic stay in the top.

Test Plan:
1. Single spike: after reset, timestep=5, spike_detected=4'b0010 for 4 cycles.
   - spike_resolved=4'b0010 exactly one cycle later.
   - evt_valid with id=1, ts=5.
   - No second event.
2. Simultaneous spikes: spike_detected=4'b1111 with evt_ready=1.
   - Grants in order 0,1,2,3 on consecutive cycles.
   - Four events, one spike_resolved pulse each.
3. Round-robin fairness: last grant=2, then spike_detected=4'b0101 held.
   - Next grant is neuron 0, then neuron 2.
4. Backpressure: evt_ready=0, DEPTH=8, 9 distinct spikes.
   - fifo_level reaches 8, fifo_full=1.
   - 9th neuron gets no spike_resolved until one pop.
   - It is captured the cycle after the pop.
5. Concurrent push/pop: level=3, evt_ready=1, one new spike.
   - fifo_level stays 3.
   - Head events leave in FIFO order.
6. Reset mid-operation: assert rst with level=4 and spike_detected[3] still high.
   - All outputs zero immediately.
   - After release, neuron 3 re-captured with the current timestep.
